// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 4;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StCsum,
    StDone,
    StErr
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word shift register: the first byte of a word lands in bits [7:0].
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_full
);

  localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

  logic [DATA_WIDTH-1:0] word_q;
  logic [CntW-1:0]       count_q;

  // Value the word takes once the byte currently offered is shifted in.
  assign word_next = {byte_in, word_q[DATA_WIDTH-1:8]};
  assign word_full = shift && (count_q == CntW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (shift) begin
      word_q  <= word_next;
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes words into the instruction SRAM,
// verifies a trailing XOR checksum and releases the core from reset on success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SRAM_ADDR_WIDTH = 8,
  parameter int unsigned WMASK_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  output logic                       rx_ready_o,
  output logic                       sram_csb_o,
  output logic                       sram_web_o,
  output logic [WMASK_WIDTH-1:0]     sram_wmask_o,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]      sram_din_o,
  output logic                       core_rst_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [SRAM_ADDR_WIDTH:0]   words_loaded_o
);

  localparam logic [31:0] MaxWords = 32'(2 ** SRAM_ADDR_WIDTH);

  loader_state_t state_q, state_d;

  logic                     xfer;
  logic                     start_ok;
  logic                     asm_shift;
  logic                     word_full;
  logic                     last_word;
  logic [DATA_WIDTH-1:0]    word_next;
  logic [31:0]              hdr_count;
  logic [SRAM_ADDR_WIDTH:0] n_q;
  logic [7:0]               csum_q;

  logic                     rx_ready_d, busy_d, core_rst_d, done_d, err_d, csb_d;
  logic [WMASK_WIDTH-1:0]   wmask_d;

  assign xfer      = rx_valid_i && rx_ready_o;
  assign start_ok  = start_i && (state_q inside {StIdle, StDone, StErr});
  assign asm_shift = xfer && (state_q inside {StHdr, StData});
  assign hdr_count = word_next[31:0];
  assign last_word = (words_loaded_o + (SRAM_ADDR_WIDTH + 1)'(1)) == n_q;

  imem_loader_byte_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .shift     (asm_shift),
    .byte_in   (rx_data_i),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: if (start_i) state_d = StHdr;
      StHdr: begin
        if (xfer && word_full) begin
          if (hdr_count > MaxWords)  state_d = StErr;
          else if (hdr_count == '0)  state_d = StCsum;
          else                       state_d = StData;
        end
      end
      StData:  if (xfer && word_full) state_d = StWrite;
      StWrite: state_d = last_word ? StCsum : StData;
      StCsum:  if (xfer) state_d = (rx_data_i == csum_q) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    rx_ready_d = state_d inside {StHdr, StData, StCsum};
    busy_d     = state_d inside {StHdr, StData, StWrite, StCsum};
    core_rst_d = state_d != StDone;
    done_d     = state_d == StDone;
    err_d      = state_d == StErr;
    csb_d      = state_d != StWrite;
    wmask_d    = (state_d == StWrite) ? '1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_o   <= 1'b0;
      busy_o       <= 1'b0;
      core_rst_o   <= 1'b1;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      sram_csb_o   <= 1'b1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= '0;
    end else begin
      rx_ready_o   <= rx_ready_d;
      busy_o       <= busy_d;
      core_rst_o   <= core_rst_d;
      done_o       <= done_d;
      err_o        <= err_d;
      sram_csb_o   <= csb_d;
      sram_web_o   <= csb_d;
      sram_wmask_o <= wmask_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q         <= '0;
      n_q            <= '0;
      words_loaded_o <= '0;
      sram_addr_o    <= '0;
      sram_din_o     <= '0;
    end else if (start_ok) begin
      csum_q         <= '0;
      n_q            <= '0;
      words_loaded_o <= '0;
    end else begin
      if (xfer && state_q == StData) csum_q <= csum_q ^ rx_data_i;
      if (state_q == StHdr && word_full) n_q <= hdr_count[SRAM_ADDR_WIDTH:0];
      if (state_q == StData && word_full) begin
        sram_addr_o <= words_loaded_o[SRAM_ADDR_WIDTH-1:0];
        sram_din_o  <= word_next;
      end
      if (state_q == StWrite) words_loaded_o <= words_loaded_o + (SRAM_ADDR_WIDTH + 1)'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard fed by the frame sender.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        sram_csb_o;
  logic        sram_web_o;
  logic [3:0]  sram_wmask_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_din_o;
  logic        core_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [8:0]  words_loaded_o;

  imem_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .rx_data_i      (rx_data_i),
    .rx_valid_i     (rx_valid_i),
    .rx_ready_o     (rx_ready_o),
    .sram_csb_o     (sram_csb_o),
    .sram_web_o     (sram_web_o),
    .sram_wmask_o   (sram_wmask_o),
    .sram_addr_o    (sram_addr_o),
    .sram_din_o     (sram_din_o),
    .core_rst_o     (core_rst_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          writes = 0;
  int          exp_addr = 0;
  logic [7:0]  csum_acc;
  logic [7:0]  last_addr;
  logic [39:0] exp_q[$];
  logic        prev_wr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM-side monitor: every write must match the scoreboard and last one cycle.
  always @(negedge clk) begin
    logic [39:0] e;
    if (prev_wr) chk("csb_one_cycle", 64'(sram_csb_o), 64'd1);
    prev_wr = 1'b0;
    if (!sram_csb_o && !sram_web_o) begin
      prev_wr   = 1'b1;
      writes++;
      last_addr = sram_addr_o;
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(sram_addr_o), 64'(e[39:32]));
        chk("wr_din", 64'(sram_din_o), 64'(e[31:0]));
        chk("wr_wmask", 64'(sram_wmask_o), 64'hF);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cnt;
    if (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid_i = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    cnt = 0;
    while (!rx_ready_o && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("rx_ready_timeout", 64'(cnt < 50), 64'd1);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] n);
    csum_acc = 8'h00;
    exp_addr = 0;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    exp_q.push_back({exp_addr[7:0], w});
    exp_addr++;
    for (int i = 0; i < 4; i++) begin
      csum_acc = csum_acc ^ w[8*i +: 8];
      send_byte(w[8*i +: 8], gaps);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_end();
    int cnt = 0;
    while (!(done_o || err_o) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("end_timeout", 64'(cnt < 100), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rx_ready"}, 64'(rx_ready_o), 64'd0);
    chk({tag, "_csb"}, 64'(sram_csb_o), 64'd1);
    chk({tag, "_web"}, 64'(sram_web_o), 64'd1);
    chk({tag, "_wmask"}, 64'(sram_wmask_o), 64'd0);
    chk({tag, "_addr"}, 64'(sram_addr_o), 64'd0);
    chk({tag, "_din"}, 64'(sram_din_o), 64'd0);
    chk({tag, "_core_rst"}, 64'(core_rst_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded_o), 64'd0);
  endtask

  initial begin
    int w0;
    rst        = 1'b1;
    start_i    = 1'b0;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Single-word frame.
    pulse_start();
    chk("t1_busy", 64'(busy_o), 64'd1);
    w0 = writes;
    send_hdr(32'd1);
    send_word(32'h0010_0513, 1'b0);
    chk("t1_csum_model", 64'(csum_acc), 64'h06);
    send_byte(8'h06, 1'b0);
    wait_end();
    chk("t1_done", 64'(done_o), 64'd1);
    chk("t1_core_rst", 64'(core_rst_o), 64'd0);
    chk("t1_words", 64'(words_loaded_o), 64'd1);
    chk("t1_writes", 64'(writes - w0), 64'd1);
    chk("t1_ready_done", 64'(rx_ready_o), 64'd0);

    // Three words with random valid gaps.
    pulse_start();
    w0 = writes;
    send_hdr(32'd3);
    send_word(32'h1111_1111, 1'b1);
    send_word(32'h2222_2222, 1'b1);
    send_word(32'h3333_3333, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_end();
    chk("t2_done", 64'(done_o), 64'd1);
    chk("t2_words", 64'(words_loaded_o), 64'd3);
    chk("t2_writes", 64'(writes - w0), 64'd3);

    // Empty frame, good then bad checksum.
    pulse_start();
    w0 = writes;
    send_hdr(32'd0);
    send_byte(8'h00, 1'b0);
    wait_end();
    chk("t3_done", 64'(done_o), 64'd1);
    chk("t3_writes", 64'(writes - w0), 64'd0);
    pulse_start();
    send_hdr(32'd0);
    send_byte(8'h5A, 1'b0);
    wait_end();
    chk("t3_err", 64'(err_o), 64'd1);
    chk("t3_done_clr", 64'(done_o), 64'd0);
    chk("t3_core_rst", 64'(core_rst_o), 64'd1);

    // Oversize header, then a full-depth load.
    pulse_start();
    w0 = writes;
    send_hdr(32'd257);
    chk("t4_err", 64'(err_o), 64'd1);
    chk("t4_ready", 64'(rx_ready_o), 64'd0);
    chk("t4_busy", 64'(busy_o), 64'd0);
    chk("t4_writes", 64'(writes - w0), 64'd0);
    pulse_start();
    w0 = writes;
    send_hdr(32'd256);
    for (int i = 0; i < 256; i++) send_word((32'h9E37_79B9 * i) ^ 32'h0F0F_5A5A, 1'b0);
    send_byte(csum_acc, 1'b0);
    wait_end();
    chk("t4_done", 64'(done_o), 64'd1);
    chk("t4_words", 64'(words_loaded_o), 64'd256);
    chk("t4_writes", 64'(writes - w0), 64'd256);
    chk("t4_last_addr", 64'(last_addr), 64'hFF);

    // Reset asserted during the write of the second word.
    pulse_start();
    send_hdr(32'd3);
    send_word(32'hCAFE_0001, 1'b0);
    send_word(32'hCAFE_0002, 1'b0);
    chk("t5_write_live", 64'(sram_csb_o), 64'd0);
    chk("t5_write_addr", 64'(sram_addr_o), 64'd1);
    #1 rst = 1'b1;
    #1 chk("t5_csb_abort", 64'(sram_csb_o), 64'd1);
    chk("t5_core_rst", 64'(core_rst_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t5_after_rst");
    pulse_start();
    send_hdr(32'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_byte(csum_acc, 1'b0);
    wait_end();
    chk("t5_done", 64'(done_o), 64'd1);
    chk("t5_words", 64'(words_loaded_o), 64'd1);

    // start_i mid-DATA is ignored; start_i in DONE restarts.
    pulse_start();
    send_hdr(32'd2);
    send_word(32'h0BAD_F00D, 1'b0);
    exp_q.push_back({exp_addr[7:0], 32'h7654_3210});
    exp_addr++;
    csum_acc = csum_acc ^ 8'h10 ^ 8'h32 ^ 8'h54 ^ 8'h76;
    send_byte(8'h10, 1'b0);
    send_byte(8'h32, 1'b0);
    pulse_start();
    chk("t6_busy_mid", 64'(busy_o), 64'd1);
    send_byte(8'h54, 1'b0);
    send_byte(8'h76, 1'b0);
    send_byte(csum_acc, 1'b0);
    wait_end();
    chk("t6_done", 64'(done_o), 64'd1);
    chk("t6_words", 64'(words_loaded_o), 64'd2);
    pulse_start();
    chk("t6_done_clr", 64'(done_o), 64'd0);
    chk("t6_core_rst", 64'(core_rst_o), 64'd1);
    chk("t6_busy", 64'(busy_o), 64'd1);
    chk("t6_words_clr", 64'(words_loaded_o), 64'd0);
    send_hdr(32'd1);
    send_word(32'h1234_5678, 1'b1);
    send_byte(csum_acc, 1'b1);
    wait_end();
    chk("t6_done2", 64'(done_o), 64'd1);
    chk("t6_words2", 64'(words_loaded_o), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader and the write-side counterpart of the instruction memory.
- Accepts a little-endian byte stream from a serial receiver through a valid/ready handshake and assembles 32-bit words.
- Writes the words through the RW port (port 0) of the sky130 OpenRAM instruction SRAM, then checks a trailing XOR checksum.
- Holds the core in reset until a load completes without error.

Parameters:
DATA_WIDTH, 32, SRAM word width; must be a multiple of 8
SRAM_ADDR_WIDTH, 8, word address width; depth = 2**SRAM_ADDR_WIDTH (256)
WMASK_WIDTH, DATA_WIDTH/8, byte write-mask width (4)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
start_i  in  1  begin a new load (single-cycle pulse; honoured only in IDLE, DONE, ERR)
rx_data_i  in  8  incoming byte
rx_valid_i  in  1  rx_data_i valid
rx_ready_o  out  1  loader can accept a byte; a transfer occurs when valid && ready
sram_csb_o  out  1  SRAM chip select, active low
sram_web_o  out  1  SRAM write enable, active low
sram_wmask_o  out  WMASK_WIDTH  byte write mask
sram_addr_o  out  SRAM_ADDR_WIDTH  word address
sram_din_o  out  DATA_WIDTH  write data
core_rst_o  out  1  core reset request, active high
busy_o  out  1  load in progress
done_o  out  1  load finished, checksum good (sticky)
err_o  out  1  load failed (sticky)
words_loaded_o  out  SRAM_ADDR_WIDTH+1  count of words written

Behaviour:
- Reset values:
  - rx_ready_o=0, sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_din_o=0.
  - core_rst_o=1, busy_o=0, done_o=0, err_o=0, words_loaded_o=0.
  - FSM in IDLE.
- All outputs are registered.
- Frame format:
  - 4 header bytes, little-endian word count N.
  - Then 4*N payload bytes; the first byte of each word goes to bits [7:0].
  - Then 1 checksum byte, equal to the XOR of all payload bytes. For N=0 the expected checksum is 0x00.
- FSM:
  - IDLE: rx_ready_o=0. start_i -> HDR; clear counters, checksum, done_o, err_o; core_rst_o=1; busy_o=1.
  - HDR: rx_ready_o=1. Collect 4 bytes into N.
    - On the 4th byte: N > 2**SRAM_ADDR_WIDTH -> ERR.
    - N == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: rx_ready_o=1. Shift bytes into the word buffer and XOR them into the checksum. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle, with rx_ready_o=0.
    - SRAM signals: csb=0, web=0, wmask=all ones, addr=word index, din=assembled word.
    - Next cycle: csb=1, web=1, index+1, words_loaded_o+1.
    - If index+1 == N -> CSUM, else -> DATA.
  - CSUM: rx_ready_o=1, one byte.
    - Match -> DONE.
    - Mismatch -> ERR.
  - DONE: done_o=1, core_rst_o=0, busy_o=0, rx_ready_o=0. start_i -> HDR.
  - ERR: err_o=1, core_rst_o=1, busy_o=0, rx_ready_o=0. start_i -> HDR.
- Latency: the 4th byte of a word is accepted at edge k; the SRAM write is presented during cycle k+1 and sampled at edge k+2.
- Gaps in rx_valid_i stall the FSM with no side effects. Bytes offered while rx_ready_o=0 are not consumed.
- start_i in HDR, DATA, WRITE or CSUM is ignored.
- Wrap: N == 2**SRAM_ADDR_WIDTH is legal. The address never wraps because the last write uses index N-1.
- Asserting rst at any point, including mid-WRITE, aborts immediately. Outputs return to reset values and csb goes high; partially written SRAM contents are undefined.
- SRAM port 1 is not driven by this block.

Decomposition:
- Package imem_loader_pkg:
  - state enum loader_state_t (IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR).
  - localparams BYTES_PER_WORD=4 and HDR_BYTES=4.
- Sub-module byte_assembler: little-endian byte-to-word shift register with a byte counter and word_full flag, reused by the HDR and DATA states.

Test Plan:
- start_i, then header 01 00 00 00, payload 13 05 10 00, checksum 06 -> one write: addr 0, din 0x00100513, wmask 1111. Then done_o=1, core_rst_o=0, words_loaded_o=1.
- N=3, words 0x11111111, 0x22222222, 0x33333333, checksum 0x00, random rx_valid_i gaps -> writes to addr 0,1,2 with the correct data, each csb low for exactly one cycle, done_o=1.
- N=0, checksum 00 -> no SRAM writes, done_o=1. Same frame with checksum 5A -> err_o=1, core_rst_o stays 1.
- Header 01 01 00 00 (N=257) -> err_o=1 after the 4th header byte, no writes, rx_ready_o=0. N=256 with correct checksum -> last write at addr 0xFF, done_o=1.
- Assert rst during the WRITE cycle of word 2 -> sram_csb_o=1 the same cycle. Then a new start_i with a fresh 1-word frame completes correctly.
- start_i pulsed mid-DATA -> ignored, frame completes. start_i in DONE -> done_o clears, core_rst_o=1, new load begins.
